// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package md_pkg;

    localparam int          WIDTH   = 32;
    localparam int          ITERS   = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    // Unsigned magnitude of a two's complement word; INT_MIN maps to 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// Start/operand/result handshake between the mult/div latch and the unit.
interface multdiv_unit_if;
    import md_pkg::*;

    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/md_addsub.sv
// 33-bit adder/subtractor shared by the Booth and non-restoring steps.
module md_addsub (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (non-restoring),
// fixed 32-iteration latency for both operations.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    multdiv_unit_if.slave        bus
);
    import md_pkg::*;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;     // Booth high half / remainder
    logic [WIDTH-1:0]   lo_q, lo_d;       // multiplier / dividend-then-quotient
    logic [WIDTH:0]     opb_q, opb_d;     // multiplicand or divisor magnitude
    logic               qm1_q, qm1_d;
    logic               neg_q, neg_d;
    logic               dexc_q, dexc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     as_a, as_sum, step_sum, acc_n;
    logic [WIDTH-1:0]   lo_n;
    logic               as_sub;
    logic [WIDTH:0]     prod_hi;
    logic               start;

    md_addsub u_addsub (
        .a   (as_a),
        .b   (opb_q),
        .sub (as_sub),
        .sum (as_sum)
    );

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;

    always_comb begin
        // Divide shifts {rem, quotient} left before the add; Booth adds in place.
        as_a     = (op_q == OP_MULT) ? acc_q : {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        as_sub   = (op_q == OP_MULT) ? (lo_q[0] & ~qm1_q) : ~acc_q[WIDTH];
        step_sum = (lo_q[0] ^ qm1_q) ? as_sum : acc_q;
        acc_n    = acc_q;
        lo_n     = lo_q;
        if (op_q == OP_MULT) begin
            acc_n = {step_sum[WIDTH], step_sum[WIDTH:1]};
            lo_n  = {step_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            acc_n = as_sum;
            lo_n  = {lo_q[WIDTH-2:0], ~as_sum[WIDTH]};
        end
        prod_hi = {acc_n[WIDTH-1:0], lo_n[WIDTH-1]};

        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        qm1_d    = qm1_q;
        neg_d    = neg_q;
        dexc_d   = dexc_q;
        result_d = result_q;
        exc_d    = exc_q;

        if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            acc_d   = '0;
            qm1_d   = 1'b0;
            if (bus.ctrl_MULT) begin
                op_d  = OP_MULT;
                lo_d  = bus.data_operandB;
                opb_d = {bus.data_operandA[WIDTH-1], bus.data_operandA};
            end else begin
                op_d   = OP_DIV;
                lo_d   = mag32(bus.data_operandA);
                opb_d  = {1'b0, mag32(bus.data_operandB)};
                neg_d  = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                dexc_d = (bus.data_operandB == '0) ||
                         (bus.data_operandA == INT_MIN && bus.data_operandB == '1);
            end
        end else begin
            case (state_q)
                RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = acc_n;
                    lo_d  = lo_n;
                    qm1_d = lo_q[0];
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_d = DONE;
                        if (op_q == OP_MULT) begin
                            result_d = lo_n;
                            exc_d    = !((&prod_hi) || (~|prod_hi));
                        end else begin
                            result_d = dexc_q ? '0 : (neg_q ? ('0 - lo_n) : lo_n);
                            exc_d    = dexc_q;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        rdy_d  = (state_d == DONE);
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        acc_q  <= acc_d;
        lo_q   <= lo_d;
        opb_q  <= opb_d;
        qm1_q  <= qm1_d;
        neg_q  <= neg_d;
        dexc_q <= dexc_d;
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed scoreboard bench for multdiv_unit: results, exceptions, latency, abort and reset.
module tb_multdiv_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        string       tag;
    } exp_t;

    exp_t sb[$];

    multdiv_unit_if bus();

    multdiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_result"}, bus.data_result, e.res);
                chk({e.tag, "_exc"}, {31'd0, bus.data_exception}, {31'd0, e.exc});
            end
        end
    end

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clk);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Called just after the start edge; expects RDY exactly 32 edges later.
    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        while (bus.data_resultRDY !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 32'd32);
        chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_rdy_pulse"}, {31'd0, bus.data_resultRDY}, 32'd0);
    endtask

    task automatic run_op(input bit m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input string tag);
        sb.push_back('{er, ee, tag});
        start_op(m, ~m, a, b);
        wait_rdy(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result", bus.data_result, 32'd0);
        chk("rst_exc", {31'd0, bus.data_exception}, 32'd0);
        chk("rst_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;

        run_op(1'b1, 32'd6, 32'd7, 32'd42, 1'b0, "mul_6x7");
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, "mul_m3x5");
        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf");
        run_op(1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "mul_min");
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd42, 1'b0, "mul_neg_neg");
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 1'b0, "div_100_7");
        run_op(1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, "div_m100_7");
        run_op(1'b0, 32'd7, 32'hFFFF_FF9C, 32'd0, 1'b0, "div_7_m100");
        run_op(1'b0, 32'd5, 32'd0, 32'd0, 1'b1, "div_by0");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "div_min_m1");
        run_op(1'b0, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, "div_min_2");

        // Both start flags high: multiply takes priority.
        sb.push_back('{32'd18, 1'b0, "both_flags"});
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        wait_rdy("both_flags");

        // Restart during RUN: the aborted multiply must never report.
        start_op(1'b1, 1'b0, 32'd3, 32'd3);
        repeat (9) @(posedge clk);
        sb.push_back('{32'd3, 1'b0, "abort_div"});
        start_op(1'b0, 1'b1, 32'd9, 32'd3);
        wait_rdy("abort_div");

        // Reset at E0+15 of a multiply: outputs clear, no RDY afterwards.
        start_op(1'b1, 1'b0, 32'd7, 32'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_result", bus.data_result, 32'd0);
        chk("mid_rst_exc", {31'd0, bus.data_exception}, 32'd0);
        chk("mid_rst_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run_op(1'b1, 32'd2, 32'd2, 32'd4, 1'b0, "mul_after_rst");

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage. It sits directly downstream of the multiply/divide pipeline latch.
- It consumes the latched A/B operands and the one-cycle mult/div start flags.
- It returns the result, an exception flag and a ready pulse. Its busy output feeds the latch's ready/stall logic.
- Fixed latency of 32 iterations for both operations, so pipeline stall timing is uniform.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must hold WIDTH-1.

Ports:
- clk  in  1  single clock domain; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_MULT  in  1  start-multiply pulse, sampled on the rising edge.
- ctrl_DIV  in  1  start-divide pulse, sampled on the rising edge.
- data_operandA  in  32  multiplicand / dividend, two's complement; captured only on the start edge.
- data_operandB  in  32  multiplier / divisor, two's complement; captured only on the start edge.
- data_result  out  32  product low word or quotient; held until the next DONE.
- data_exception  out  1  overflow or divide-by-zero; held with data_result.
- data_resultRDY  out  1  one-cycle pulse, high while in DONE.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state goes to IDLE; counter = 0.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
  - Reset in any state aborts the operation with no RDY pulse.
- States: IDLE, RUN, DONE.
- Start:
  - An edge with ctrl_MULT or ctrl_DIV high, in any state, latches both operands and the operation, clears the counter and enters RUN.
  - If both ctrl_MULT and ctrl_DIV are high, MULT wins.
  - A start arriving during RUN aborts the current operation and restarts; the old result is never reported.
  - A start arriving in DONE still gives RDY its full cycle, then the new op begins.
- RUN:
  - One iteration per edge; counter increments each edge.
  - On the edge where counter == 31, the final step completes, the result registers are written and state goes to DONE.
- Latency: start sampled on edge E0; RDY is high during the cycle after edge E0+32. That is 32 edges, identical for MULT and DIV, including exception cases.
- DONE: RDY = 1 for exactly one cycle, then IDLE (or RUN if a start is sampled on that edge).
- Multiply (radix-2 Booth):
  - 65-bit product register {acc[32:0], multiplier[31:0]} plus a Booth bit q-1.
  - Each step adds/subtracts the sign-extended 33-bit multiplicand according to {q0, q-1}, then arithmetic right shift by 1.
  - data_result = product[31:0].
  - data_exception = 1 when product[63:31] is not all-equal (signed overflow); data_result still shows the low word.
- Divide (non-restoring on magnitudes):
  - Operate on |A| and |B| with a 33-bit remainder; quotient is truncated toward zero.
  - Quotient is negated when the sign of A differs from the sign of B. Remainder is discarded.
  - B == 0: data_result = 0, data_exception = 1.
  - A = 0x80000000 and B = 0xFFFFFFFF: data_result = 0, data_exception = 1.
  - |A| = 2^31 is handled correctly for any other B (33-bit magnitude path).
- Operand changes on the input ports after the start edge have no effect.
- busy = 1 exactly in RUN. Upstream deasserts its stall when RDY is seen.

Decomposition:
- Shared package md_pkg holds:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - op encoding: OP_MULT, OP_DIV.
  - constants WIDTH = 32, ITERS = 32, INT_MIN = 32'h80000000.
- One natural sub-module: md_addsub, a 33-bit add/subtract (a, b, sub -> sum), shared by the Booth step and the non-restoring step.
- FSM, counter and shift registers stay in multdiv_unit.

Test Plan:
- MULT 6 x 7, start at E0 -> RDY high only in the cycle after E0+32; result 42, exc 0; busy high for 32 cycles before.
- MULT -3 x 5 -> 0xFFFFFFF1, exc 0. MULT 0x00010000 x 0x00010000 -> result 0x00000000, exc 1. MULT 0x80000000 x 1 -> 0x80000000, exc 0.
- DIV 100 / 7 -> 14; -100 / 7 -> 0xFFFFFFF2 (-14); 7 / -100 -> 0; all exc 0, same 32-edge latency.
- DIV 5 / 0 -> result 0, exc 1 with 32-edge latency. DIV 0x80000000 / -1 -> result 0, exc 1. DIV 0x80000000 / 2 -> 0xC0000000, exc 0.
- Start MULT 3 x 3, then start DIV 9 / 3 on edge E0+10 -> no RDY at E0+32; single RDY after E0+42 with result 3.
- Reset asserted at E0+15 of a MULT -> all outputs 0 next cycle, no RDY; a new MULT 2 x 2 afterwards -> 4 with normal latency.
